conv_ascii_opcode: RTL and testbench

//  Registered decoder that maps an ASCII operator character received over the UART

---
 rtl/conv_ascii_opcode.sv | 113 +++++++++++
 tb/tb_conv_ascii_opcode.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/conv_ascii_opcode.sv
// -----------------------------------------------------------------------------
// conv_ascii_opcode
//
// Purpose:
//   Registered decoder from an ASCII operator character (as received from the
//   UART RX byte stream) to the 8-bit ALU operation code (MIPS-style funct
//   encoding). Characters that are not legal operators are flagged. They are
//   also counted in a saturating error counter.
//
// Configuration:
//   CONV_LOWERCASE_EN  When defined, 'a', 'o', 'x' and 'n' decode exactly like
//                      their uppercase forms. When undefined, every lowercase
//                      letter is illegal.
//
// Parameters:
//   DATA_W    width of the ASCII input and the opcode output (only 8 supported)
//   INV_CODE  opcode driven for an illegal character
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   ascii_valid   in   ASCII holds a new character this cycle
//   ASCII         in   received character code
//   opcode        out  decoded operation code (registered)
//   opcode_valid  out  one-cycle pulse: opcode/invalid were updated
//   invalid       out  last decoded character was not a legal operator
//   err_cnt       out  illegal characters since reset, saturating at 0xFF
// -----------------------------------------------------------------------------
module conv_ascii_opcode #(
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  INV_CODE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ascii_valid,
    input  logic [DATA_W-1:0] ASCII,
    output logic [DATA_W-1:0] opcode,
    output logic              opcode_valid,
    output logic              invalid,
    output logic [7:0]        err_cnt
);

    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic              opcode_valid_q, opcode_valid_d;
    logic              invalid_q, invalid_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    // Combinational lookup of the incoming character
    logic [DATA_W-1:0] lut_code;
    logic              lut_legal;

    always_comb begin
        lut_legal = 1'b1;
        lut_code  = INV_CODE;
        // Full 8-bit compare: characters with bit 7 set never match
        case (ASCII)
            8'h2B: lut_code = 8'h20;   // '+' ADD
            8'h2D: lut_code = 8'h22;   // '-' SUB
            8'h41: lut_code = 8'h24;   // 'A' AND
            8'h4F: lut_code = 8'h25;   // 'O' OR
            8'h58: lut_code = 8'h26;   // 'X' XOR
            8'h4E: lut_code = 8'h27;   // 'N' NOR
            8'h3E: lut_code = 8'h03;   // '>' SRA
            8'h2F: lut_code = 8'h02;   // '/' SRL
`ifdef CONV_LOWERCASE_EN
            8'h61: lut_code = 8'h24;   // 'a' AND
            8'h6F: lut_code = 8'h25;   // 'o' OR
            8'h78: lut_code = 8'h26;   // 'x' XOR
            8'h6E: lut_code = 8'h27;   // 'n' NOR
`else
`endif
            default: begin
                lut_legal = 1'b0;
                lut_code  = INV_CODE;
            end
        endcase
    end

    always_comb begin
        opcode_d       = opcode_q;
        invalid_d      = invalid_q;
        err_cnt_d      = err_cnt_q;
        opcode_valid_d = ascii_valid;
        if (ascii_valid) begin
            opcode_d  = lut_code;
            invalid_d = ~lut_legal;
            // Saturate rather than wrap so a flood of garbage stays visible
            if (!lut_legal && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q       <= INV_CODE;
            opcode_valid_q <= 1'b0;
            invalid_q      <= 1'b0;
            err_cnt_q      <= 8'h00;
        end else begin
            opcode_q       <= opcode_d;
            opcode_valid_q <= opcode_valid_d;
            invalid_q      <= invalid_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign opcode       = opcode_q;
    assign opcode_valid = opcode_valid_q;
    assign invalid      = invalid_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_conv_ascii_opcode.sv
// -----------------------------------------------------------------------------
// tb_conv_ascii_opcode
//
// Randomized, self-checking bench for conv_ascii_opcode. Expected values come
// from a table-driven reference model of the operator set. The model also
// tracks a plain integer error count that is clamped to 255.
// -----------------------------------------------------------------------------
module tb_conv_ascii_opcode;

    logic       clk;
    logic       rst_n;
    logic       ascii_valid;
    logic [7:0] ascii_in;
    logic [7:0] opcode;
    logic       opcode_valid;
    logic       invalid;
    logic [7:0] err_cnt;

    int test_cnt = 0;
    int fail_cnt = 0;

    // Reference model state
    int   m_opcode;
    int   m_valid;
    int   m_invalid;
    int   m_err;

    // Operator table
    byte  op_chars [8] = '{8'h2B, 8'h2D, 8'h41, 8'h4F, 8'h58, 8'h4E, 8'h3E, 8'h2F};
    byte  op_codes [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};

    conv_ascii_opcode #(.DATA_W(8), .INV_CODE(8'h00)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ascii_valid  (ascii_valid),
        .ASCII        (ascii_in),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .invalid      (invalid),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        test_cnt++;
        if (got != exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Returns the opcode for a character, or -1 if the character is illegal
    function automatic int ref_lookup(input int ch);
        int c;
        c = ch;
`ifdef CONV_LOWERCASE_EN
        if (c == 'h61 || c == 'h6F || c == 'h78 || c == 'h6E) c = c - 32;
`endif
        for (int i = 0; i < 8; i++) begin
            if (int'(op_chars[i]) == c) return int'(op_codes[i]);
        end
        return -1;
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".opcode"},  int'(opcode),       m_opcode);
        check_val({tag, ".ovalid"},  int'(opcode_valid), m_valid);
        check_val({tag, ".invalid"}, int'(invalid),      m_invalid);
        check_val({tag, ".err_cnt"}, int'(err_cnt),      m_err);
    endtask

    task automatic model_reset();
        m_opcode  = 0;
        m_valid   = 0;
        m_invalid = 0;
        m_err     = 0;
    endtask

    // Apply one cycle of stimulus, then compare after the edge
    task automatic step(input bit v, input int ch, input string tag, input bit verbose);
        int code;
        @(negedge clk);
        ascii_valid = v;
        ascii_in    = 8'(ch);
        @(posedge clk);
        #1;
        m_valid = v;
        if (v) begin
            code = ref_lookup(ch);
            if (code < 0) begin
                m_opcode  = 0;
                m_invalid = 1;
                if (m_err < 255) m_err++;
            end else begin
                m_opcode  = code;
                m_invalid = 0;
            end
        end
        check_outputs(tag);
        if (verbose)
            $display("[TB] %s v=%0d ch=0x%02h -> opcode=0x%02h ov=%0d inv=%0d err=%0d",
                     tag, v, ch & 'hFF, opcode, opcode_valid, invalid, err_cnt);
    endtask

    initial begin
        int ch;
        bit v;
        rst_n       = 1'b0;
        ascii_valid = 1'b0;
        ascii_in    = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Every operator on consecutive cycles
        foreach (op_chars[i]) step(1'b1, int'(op_chars[i]), "table", 1'b1);

        // Illegal 'Z', then a legal '+'
        step(1'b1, 'h5A, "illegal_Z", 1'b1);
        step(1'b1, 'h2B, "plus_after_Z", 1'b1);

        // No valid: outputs hold while ASCII toggles
        for (int i = 0; i < 4; i++) step(1'b0, $urandom_range(0, 255), "hold", 1'b1);

        // Lowercase 'a' (result depends on build option)
        step(1'b1, 'h61, "lower_a", 1'b1);

        // Bit 7 set: always illegal
        step(1'b1, 'hAB, "bit7", 1'b1);
        step(1'b1, 'h80 | 'h2B, "bit7_plus", 1'b1);

        // Random mix of legal operators and arbitrary bytes
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) ch = int'(op_chars[$urandom_range(0, 7)]);
            else                           ch = $urandom_range(0, 255);
            step(v, ch, "rand", 1'b1);
        end

        // Asynchronous reset mid-stream with a character pending
        @(negedge clk);
        ascii_valid = 1'b1;
        ascii_in    = 8'h5A;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst");
        $display("[TB] async_rst opcode=0x%02h ov=%0d inv=%0d err=%0d",
                 opcode, opcode_valid, invalid, err_cnt);
        @(posedge clk);
        #1;
        check_outputs("async_rst_hold");
        @(negedge clk);
        ascii_valid = 1'b0;
        rst_n = 1'b1;

        // Saturation: 300 illegal characters
        for (int i = 0; i < 300; i++) step(1'b1, 'h5A, "sat", 1'b0);
        check_val("sat.final", int'(err_cnt), 255);
        $display("[TB] sat err_cnt=%0d after 300 illegal", err_cnt);
        step(1'b1, 'h2D, "legal_after_sat", 1'b1);
        step(1'b1, 'h00, "illegal_after_sat", 1'b1);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

    // Absolute bound on run time
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
